// File: rtl/div4_seq_ctrl.sv
// rtl/div4_seq_ctrl.sv - restoring-division sequencer driving an external (WIDTH+1)-bit subtractor.
// Optional zero-divisor trap: define DIV_ZERO_TRAP_EN.
module div4_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH:0]   sub_a,
    output logic [WIDTH:0]   sub_b,
    input  logic [WIDTH:0]   sub_diff,
    input  logic             sub_borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The partial remainder never exceeds the divisor, so the difference MSB carries no information.
    logic diff_msb_unused;
    assign diff_msb_unused = sub_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        sub_a   = '0;
        sub_b   = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    r_d     = '0;
                    q_d     = dividend;
                    d_d     = divisor;
                    cnt_d   = CW'(WIDTH - 1);
                    dbz_d   = (divisor == '0);
                    state_d = S_ITER;
`ifdef DIV_ZERO_TRAP_EN
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_ITER: begin
                // Shift the next dividend bit into the partial remainder and try the subtraction.
                sub_a = {r_q, q_q[WIDTH-1]};
                sub_b = {1'b0, d_q};
                if (!sub_borrow) begin
                    r_d = sub_diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = sub_a[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready       = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy        = (state_q == S_ITER);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// tb/tb_div4_seq_ctrl.sv - scoreboard bench for div4_seq_ctrl with a behavioural subtractor.
module tb_div4_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [W:0]   sub_a;
    logic [W:0]   sub_b;
    logic [W:0]   sub_diff;
    logic         sub_borrow;

    typedef struct {
        int q;
        int r;
        int dbz;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_q = 0;
    int   last_r = 0;

    div4_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_diff    (sub_diff),
        .sub_borrow  (sub_borrow)
    );

    assign sub_diff   = sub_a - sub_b;
    assign sub_borrow = (sub_a < sub_b);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned division by plain arithmetic, with the all-ones/dividend zero-divisor result.
    function automatic exp_t model(input int a, input int b, input int now);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.dbz = 1;
`ifdef DIV_ZERO_TRAP_EN
            e.due = now + 1;
`else
            e.due = now + W + 1;
`endif
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 0;
            e.due = now + W + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_q = quotient;
            last_r = remainder;
        end else begin
            chk("ready_vs_busy", ready, !busy);
            if (!busy) chk("sub_idle_zero", {sub_a, sub_b}, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("done_cycle", cyc, e.due);
                end
            end else begin
                chk("result_stable", {quotient, remainder}, {last_q[W-1:0], last_r[W-1:0]});
            end
            last_q = quotient;
            last_r = remainder;
        end
    end

    // Called at a negedge; returns at a negedge with start low unless the next call re-asserts it.
    task automatic issue(input int a, input int b, input bit hold);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        if (hold) begin
            while (busy) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_results", {quotient, remainder, div_by_zero}, 0);
        chk("rst_sub", {sub_a, sub_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(13, 3, 0);
        drain();
        issue(15, 1, 0);
        issue(7, 9, 0);
        drain();
        issue(13, 3, 1);
        drain();
        issue(9, 0, 0);
        drain();

        // Reset asserted mid-way through the second ITER cycle.
        dividend = 4'd11;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_results", {quotient, remainder, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(6, 2, 0);
        drain();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a, b, 0);
            end
        end
        drain();

        for (int i = 0; i < 80; i++) begin
            issue(int'($urandom_range(15)), int'($urandom_range(15)), bit'($urandom_range(1)));
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
